// File: rtl/mtr_drv_pwm.sv
// mtr_drv_pwm: motor-drive PWM back end for two H-bridges.
// Converts signed 11-bit speed words into complementary high/low-side
// gate drives with a programmable dead time between them. Speeds are
// double-buffered and change only on PWM period boundaries.
// Optional feature: define SLEW_LIMIT_EN to limit how far the applied
// duty may move per period (by SLEW_STEP counts).
module mtr_drv_pwm #(
  parameter int NONOVERLAP = 8,
  parameter int SLEW_STEP  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [10:0] lft_spd,
  input  logic signed [10:0] rght_spd,
  output logic               lft_pwm1,
  output logic               lft_pwm2,
  output logic               rght_pwm1,
  output logic               rght_pwm2,
  output logic               prd_strt
);

  localparam logic [10:0] CNT_LAST  = 11'h7FF;
  localparam logic [10:0] DUTY_ZERO = 11'h400;
  localparam logic [5:0]  NOV_LOAD  = 6'(NONOVERLAP);
  localparam logic [5:0]  NOV_EDGE  = 6'(NONOVERLAP - 1);

  // Index 0 is the left motor, index 1 the right motor.
  logic [10:0] cnt_q;
  logic        prdStrt_q;
  logic [10:0] spdNxt [2];
  logic [10:0] duty_d [2];
  logic [10:0] duty_q [2];
  logic [1:0]  raw_q;
  logic [1:0]  rawDly_q;
  logic [5:0]  nov_q [2];
  logic [1:0]  pwm1_q;
  logic [1:0]  pwm2_q;

`ifdef SLEW_LIMIT_EN
  localparam logic signed [11:0] STEP_S = 12'(SLEW_STEP);
  localparam logic [10:0]        STEP_U = 11'(SLEW_STEP);
  logic signed [11:0] diff [2];

  // Move the applied duty toward the requested one by at most one step.
  always_comb begin
    spdNxt[0] = lft_spd ^ DUTY_ZERO;
    spdNxt[1] = rght_spd ^ DUTY_ZERO;
    for (int s = 0; s < 2; s++) begin
      duty_d[s] = duty_q[s];
      diff[s]   = $signed({1'b0, spdNxt[s]}) - $signed({1'b0, duty_q[s]});
      if (diff[s] > STEP_S) begin
        duty_d[s] = duty_q[s] + STEP_U;
      end else if (diff[s] < -STEP_S) begin
        duty_d[s] = duty_q[s] - STEP_U;
      end else begin
        duty_d[s] = spdNxt[s];
      end
    end
  end
`else
  logic unusedSlewStep;
  assign unusedSlewStep = ^32'(SLEW_STEP);

  // Without slew limiting the requested duty is taken as-is.
  always_comb begin
    spdNxt[0] = lft_spd ^ DUTY_ZERO;
    spdNxt[1] = rght_spd ^ DUTY_ZERO;
    for (int s = 0; s < 2; s++) begin
      duty_d[s] = spdNxt[s];
    end
  end
`endif

  // Free-running period counter and registered period-start strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      prdStrt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_q + 11'd1;
      prdStrt_q <= (cnt_q == CNT_LAST);
    end
  end

  // Applied duties only change on the last count so a period is never cut.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        duty_q[s] <= DUTY_ZERO;
      end
    end else if (cnt_q == CNT_LAST) begin
      for (int s = 0; s < 2; s++) begin
        duty_q[s] <= duty_d[s];
      end
    end
  end

  // Raw PWM compare and dead-time insertion around every raw edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q    <= '0;
      rawDly_q <= '0;
      pwm1_q   <= '0;
      pwm2_q   <= '0;
      for (int s = 0; s < 2; s++) begin
        nov_q[s] <= NOV_LOAD;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        raw_q[s]    <= (cnt_q < duty_q[s]);
        rawDly_q[s] <= raw_q[s];
        if (raw_q[s] != rawDly_q[s]) begin
          nov_q[s]  <= NOV_EDGE;
          pwm1_q[s] <= 1'b0;
          pwm2_q[s] <= 1'b0;
        end else if (nov_q[s] != 6'd0) begin
          nov_q[s]  <= nov_q[s] - 6'd1;
          pwm1_q[s] <= 1'b0;
          pwm2_q[s] <= 1'b0;
        end else begin
          pwm1_q[s] <= raw_q[s];
          pwm2_q[s] <= ~raw_q[s];
        end
      end
    end
  end

  assign lft_pwm1  = pwm1_q[0];
  assign lft_pwm2  = pwm2_q[0];
  assign rght_pwm1 = pwm1_q[1];
  assign rght_pwm2 = pwm2_q[1];
  assign prd_strt  = prdStrt_q;

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// tb_mtr_drv_pwm: directed bench for mtr_drv_pwm with default parameters
// (NONOVERLAP 8) and SLEW_LIMIT_EN undefined. Pulse widths are counted
// over whole periods aligned to prd_strt (cnt 0..2047).
module tb_mtr_drv_pwm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] lft_spd = 11'h000;
  logic [10:0] rght_spd = 11'h000;
  logic        lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, prd_strt;

  int checks = 0;
  int errors = 0;
  int l1, l2, r1, r2, r2MaxLow, postL1, postR1, firstPrd, earlyHigh;

  mtr_drv_pwm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .lft_pwm1  (lft_pwm1),
    .lft_pwm2  (lft_pwm2),
    .rght_pwm1 (rght_pwm1),
    .rght_pwm2 (rght_pwm2),
    .prd_strt  (prd_strt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a negedge sample with prd_strt high.
  task automatic waitPrd(output bit ok);
    int k;
    ok = 1'b0;
    k = 0;
    while (!ok && k < 4200) begin
      @(negedge clk);
      k++;
      if (prd_strt) ok = 1'b1;
    end
  endtask

  // Count output high time over one period; optionally change lft_spd at a given cnt.
  task automatic measurePeriod(input string tag, input int changeAt, input logic [10:0] newLft);
    bit ok;
    int prdCnt, ovl, ovr, run;
    waitPrd(ok);
    check({tag, "_prd_found"}, int'(ok), 1);
    l1 = 0; l2 = 0; r1 = 0; r2 = 0; r2MaxLow = 0;
    prdCnt = 0; ovl = 0; ovr = 0; run = 0;
    for (int i = 0; i < 2048; i++) begin
      if (i > 0) @(negedge clk);
      l1 += int'(lft_pwm1);
      l2 += int'(lft_pwm2);
      r1 += int'(rght_pwm1);
      r2 += int'(rght_pwm2);
      prdCnt += int'(prd_strt);
      if (lft_pwm1 && lft_pwm2) ovl++;
      if (rght_pwm1 && rght_pwm2) ovr++;
      if (!rght_pwm2) begin
        run++;
        if (run > r2MaxLow) r2MaxLow = run;
      end else begin
        run = 0;
      end
      if (i == changeAt) lft_spd = newLft;
    end
    check({tag, "_prd_per_period"}, prdCnt, 1);
    check({tag, "_lft_overlap"}, ovl, 0);
    check({tag, "_rght_overlap"}, ovr, 0);
  endtask

  // Release reset just after a negedge and observe the first 2048 clocks.
  task automatic applyStimulus(input string tag);
    rst_n = 1'b1;
    postL1 = 0; postR1 = 0; firstPrd = 0; earlyHigh = 0;
    for (int j = 1; j <= 2048; j++) begin
      @(negedge clk);
      if (j <= 8 && (lft_pwm1 || lft_pwm2 || rght_pwm1 || rght_pwm2)) earlyHigh++;
      postL1 += int'(lft_pwm1);
      postR1 += int'(rght_pwm1);
      if (prd_strt && firstPrd == 0) firstPrd = j;
    end
    check({tag, "_early_low"}, earlyHigh, 0);
    check({tag, "_lft_pwm1_first"}, postL1, 1016);
    check({tag, "_rght_pwm1_first"}, postR1, 1016);
    check({tag, "_first_prd_strt"}, firstPrd, 2048);
  endtask

  task automatic checkOutput(input string tag, input int el1, input int el2, input int er1, input int er2);
    check({tag, "_lft_pwm1"}, l1, el1);
    check({tag, "_lft_pwm2"}, l2, el2);
    check({tag, "_rght_pwm1"}, r1, er1);
    check({tag, "_rght_pwm2"}, r2, er2);
  endtask

  initial begin
    // Test 1: reset, zero speed on both sides.
    repeat (3) @(negedge clk);
    check("rst_outputs", int'({lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, prd_strt}), 0);
    applyStimulus("t1");
    measurePeriod("t1", -1, 11'h000);
    checkOutput("t1", 1016, 1016, 1016, 1016);

    // Test 2: +512 left (duty 1536), -512 right (duty 512).
    lft_spd = 11'h200;
    rght_spd = 11'h600;
    measurePeriod("t2a", -1, 11'h000);
    measurePeriod("t2", -1, 11'h000);
    checkOutput("t2", 1528, 504, 504, 1528);

    // Test 3: left change mid-period only takes effect next period.
    lft_spd = 11'h000;
    measurePeriod("t3a", -1, 11'h000);
    measurePeriod("t3b", 700, 11'd300);
    checkOutput("t3b", 1016, 1016, 504, 1528);
    measurePeriod("t3c", -1, 11'h000);
    checkOutput("t3c", 1316, 716, 504, 1528);

    // Test 4: right full reverse, then a duty-4 runt that must be suppressed.
    rght_spd = 11'h400;
    measurePeriod("t4a", -1, 11'h000);
    measurePeriod("t4b", -1, 11'h000);
    check("t4b_rght_pwm1", r1, 0);
    check("t4b_rght_pwm2", r2, 2048);
    rght_spd = 11'h404;
    measurePeriod("t4c", -1, 11'h000);
    measurePeriod("t4d", -1, 11'h000);
    check("t4d_rght_pwm1", r1, 0);
    check("t4d_rght_pwm2", r2, 2036);
    check("t4d_rght_pwm2_low_run", r2MaxLow, 12);

    // Test 5: asynchronous reset at cnt 1500 while left pwm1 is high.
    lft_spd = 11'h200;
    rght_spd = 11'h000;
    measurePeriod("t5a", -1, 11'h000);
    begin
      bit ok;
      waitPrd(ok);
      check("t5_prd_found", int'(ok), 1);
    end
    repeat (1500) @(negedge clk);
    check("t5_lft_pwm1_before", int'(lft_pwm1), 1);
    check("t5_rght_pwm2_before", int'(rght_pwm2), 1);
    #2 rst_n = 1'b0;
    #1 check("t5_async_drop", int'({lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, prd_strt}), 0);
    repeat (4) @(negedge clk);
    check("t5_held_low", int'({lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, prd_strt}), 0);
    applyStimulus("t5");

    // Test 6: full-forward step applies in one go without slew limiting.
    lft_spd = 11'h3FF;
    measurePeriod("t6a", -1, 11'h000);
    measurePeriod("t6", -1, 11'h000);
    check("t6_lft_pwm1", l1, 2039);
    check("t6_lft_pwm2", l2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
